// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive to local logic and byte transmit from local logic, open-drain SDA.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rw_flag,
  output logic       busy,
  output logic       addr_hit
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  logic [7:0] sh_reg, sh_nxt, byte_in, rx_data_nxt;
  logic [2:0] bit_cnt, cnt_nxt;
  logic       phase, phase_nxt;
  logic       oe_nxt, rx_valid_nxt, tx_load_nxt, rw_nxt, busy_nxt, hit_nxt;
  logic       last_bit, match;

  // Input synchronisers idle high like the bus itself
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = sda_d & ~sda_s & scl_s;
  assign stop     = ~sda_d & sda_s & scl_s;
  assign byte_in  = {sh_reg[6:0], sda_s};
  assign last_bit = scl_rise && (bit_cnt == 3'd7);
  assign match    = (byte_in[7:1] == DEV_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop)       state_nxt = IDLE;
    else if (start) state_nxt = ADDR;
    else begin
      case (state)
        ADDR:     if (last_bit) state_nxt = match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && phase) state_nxt = rw_flag ? RD_DATA : WR_DATA;
        WR_DATA:  if (last_bit) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall && phase) state_nxt = WR_DATA;
        RD_DATA:  if (scl_fall && phase) state_nxt = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s)       state_nxt = WAIT_STOP;
          else if (scl_fall && phase)  state_nxt = RD_DATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // phase marks the second half of a two-fall sequence (ACK slot, or byte end on reads)
  always_comb begin
    oe_nxt       = sda_oe;
    sh_nxt       = sh_reg;
    cnt_nxt      = bit_cnt;
    phase_nxt    = phase;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_load_nxt  = 1'b0;
    rw_nxt       = rw_flag;
    busy_nxt     = busy;
    hit_nxt      = 1'b0;
    if (stop) begin
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      phase_nxt = 1'b0;
      cnt_nxt   = 3'd0;
    end else if (start) begin
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b1;
      phase_nxt = 1'b0;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_nxt  = byte_in;
          cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7 && match) begin
            rw_nxt  = byte_in[0];
            hit_nxt = 1'b1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_nxt    = 1'b1;
            phase_nxt = 1'b1;
            if (rw_flag) begin
              tx_load_nxt = 1'b1;
              sh_nxt      = tx_data;
            end
          end else begin
            phase_nxt = 1'b0;
            cnt_nxt   = 3'd0;
            oe_nxt    = rw_flag & ~sh_reg[7];
            if (rw_flag) sh_nxt = {sh_reg[6:0], 1'b0};
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_nxt  = byte_in;
          cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
          end
        end
        WR_ACK: if (scl_fall) begin
          oe_nxt    = ~phase;
          phase_nxt = ~phase;
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) phase_nxt = 1'b1;
          end else if (scl_fall) begin
            if (phase) begin
              oe_nxt    = 1'b0;
              phase_nxt = 1'b0;
            end else begin
              oe_nxt = ~sh_reg[7];
              sh_nxt = {sh_reg[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !sda_s) begin
            tx_load_nxt = 1'b1;
            sh_nxt      = tx_data;
            phase_nxt   = 1'b1;
          end else if (scl_fall && phase) begin
            oe_nxt    = ~sh_reg[7];
            sh_nxt    = {sh_reg[6:0], 1'b0};
            phase_nxt = 1'b0;
            cnt_nxt   = 3'd0;
          end
        end
        default: oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    sh_reg <= sh_nxt;
    if (reset) begin
      sda_oe   <= 1'b0;
      bit_cnt  <= 3'd0;
      phase    <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      rw_flag  <= 1'b0;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
    end else begin
      sda_oe   <= oe_nxt;
      bit_cnt  <= cnt_nxt;
      phase    <= phase_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_load  <= tx_load_nxt;
      rw_flag  <= rw_nxt;
      busy     <= busy_nxt;
      addr_hit <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master on a wired-AND SDA, with a
// scoreboard of expected received bytes and R/W flags checked on DUT pulses.
module tb_i2c_target;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk, reset, m_scl, m_sda;
  logic       scl_in, sda_in, sda_oe;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_load, rw_flag, busy, addr_hit;

  int checks, errors, tx_cnt, oe_cnt;
  logic [7:0] exp_rx_q[$];
  logic       exp_rw_q[$];
  logic [7:0] tx_src[$];

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .rw_flag(rw_flag),
    .busy(busy), .addr_hit(addr_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n = Q);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic got, output logic oe);
    wq(); m_sda = b;
    wq(); m_scl = 1'b1;
    wq(); got = sda_in; oe = sda_oe;
    wq(); m_scl = 1'b0;
  endtask

  task automatic start_c();
    wq(); m_sda = 1'b1;
    wq(); m_scl = 1'b1;
    wq(); m_sda = 1'b0;
    wq(); m_scl = 1'b0;
  endtask

  task automatic stop_c();
    wq(); m_sda = 1'b0;
    wq(); m_scl = 1'b1;
    wq(); m_sda = 1'b1;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_oe);
    logic g, o;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], g, o);
    bit_xfer(1'b1, g, ack_oe);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic g, o;
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, g, o);
      t[i] = g;
    end
    bit_xfer(nack, g, o);
    d = t;
  endtask

  initial begin
    logic a;
    logic [7:0] d;
    int t0, o0;
    checks = 0; errors = 0; tx_cnt = 0; oe_cnt = 0;
    tx_data = 8'h00;
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (sda_oe) oe_cnt++;
          if (rx_valid || tx_load) check_val("rx_tx_excl", rx_valid & tx_load, 0);
          if (addr_hit) begin
            if (exp_rw_q.size() == 0) check_val("hit_unexpected", addr_hit, 0);
            else check_val("rw_flag", rw_flag, exp_rw_q.pop_front());
          end
          if (rx_valid) begin
            if (exp_rx_q.size() == 0) check_val("rx_unexpected", rx_valid, 0);
            else check_val("rx_data", rx_data, exp_rx_q.pop_front());
          end
          if (tx_load) begin
            tx_cnt++;
            if (tx_src.size() != 0) void'(tx_src.pop_front());
          end
        end
        tx_data = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
      end
      begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    wq(5);
    check_val("rst_sda_oe", sda_oe, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_tx_load", tx_load, 0);
    check_val("rst_rw_flag", rw_flag, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_addr_hit", addr_hit, 0);
    reset = 1'b0;
    wq(4);

    // Write to matching address
    exp_rw_q.push_back(1'b0);
    start_c();
    check_val("w_busy", busy, 1);
    send_byte(8'h54, a);       check_val("w_addr_ack", a, 1);
    exp_rx_q.push_back(8'hA5);
    send_byte(8'hA5, a);       check_val("w_data_ack", a, 1);
    stop_c();
    check_val("w_busy_after", busy, 0);
    check_val("w_rx_data", rx_data, 8'hA5);

    // Address mismatch
    o0 = oe_cnt;
    start_c();
    send_byte(8'h56, a);       check_val("mm_addr_ack", a, 0);
    send_byte(8'hFF, a);       check_val("mm_data_ack", a, 0);
    check_val("mm_busy", busy, 1);
    stop_c();
    check_val("mm_busy_after", busy, 0);
    check_val("mm_oe_cycles", oe_cnt - o0, 0);

    // Two-byte read, ACK then NACK
    t0 = tx_cnt;
    tx_src.push_back(8'h3C);
    tx_src.push_back(8'hC3);
    exp_rw_q.push_back(1'b1);
    start_c();
    send_byte(8'h55, a);       check_val("r_addr_ack", a, 1);
    read_byte(1'b0, d);        check_val("r_byte1", d, 8'h3C);
    read_byte(1'b1, d);        check_val("r_byte2", d, 8'hC3);
    wq();
    check_val("r_oe_after_nack", sda_oe, 0);
    check_val("r_tx_loads", tx_cnt - t0, 2);
    stop_c();
    check_val("r_busy_after", busy, 0);

    // Repeated START: write then read
    exp_rw_q.push_back(1'b0);
    start_c();
    send_byte(8'h54, a);       check_val("sr_waddr_ack", a, 1);
    exp_rx_q.push_back(8'h11);
    send_byte(8'h11, a);       check_val("sr_wdata_ack", a, 1);
    check_val("sr_rw0", rw_flag, 0);
    tx_src.push_back(8'h7E);
    exp_rw_q.push_back(1'b1);
    start_c();
    send_byte(8'h55, a);       check_val("sr_raddr_ack", a, 1);
    read_byte(1'b1, d);        check_val("sr_rbyte", d, 8'h7E);
    check_val("sr_rx_data", rx_data, 8'h11);
    check_val("sr_rw1", rw_flag, 1);
    stop_c();

    // Early STOP after four data bits
    exp_rw_q.push_back(1'b0);
    start_c();
    send_byte(8'h54, a);       check_val("es_addr_ack", a, 1);
    for (int i = 0; i < 4; i++) bit_xfer(i[0], d[0], a);
    stop_c();
    wq();
    check_val("es_busy", busy, 0);
    check_val("es_sda_oe", sda_oe, 0);
    check_val("es_rx_data", rx_data, 8'h11);

    // Reset while driving a write ACK, then a normal transfer
    exp_rw_q.push_back(1'b0);
    start_c();
    send_byte(8'h54, a);       check_val("ra_addr_ack", a, 1);
    exp_rx_q.push_back(8'h99);
    d = 8'h99;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], a, a);
    wq(); m_sda = 1'b1;
    wq(); m_scl = 1'b1;
    wq();
    check_val("ra_oe_before", sda_oe, 1);
    reset = 1'b1;
    wq(1);
    check_val("ra_oe_reset", sda_oe, 0);
    check_val("ra_busy_reset", busy, 0);
    check_val("ra_rx_reset", rx_data, 0);
    reset = 1'b0;
    wq(); m_scl = 1'b0;
    exp_rw_q.push_back(1'b0);
    start_c();
    send_byte(8'h54, a);       check_val("ra2_addr_ack", a, 1);
    exp_rx_q.push_back(8'h5A);
    send_byte(8'h5A, a);       check_val("ra2_data_ack", a, 1);
    stop_c();
    check_val("ra2_rx_data", rx_data, 8'h5A);
    check_val("ra2_busy", busy, 0);

    check_val("rx_q_drained", exp_rx_q.size(), 0);
    check_val("rw_q_drained", exp_rw_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
